// File: rtl/data_sync_pkg.sv
// data_sync_pkg: shared types and constants for the data_sync bus synchronizer.
//   state_e          guard-window FSM encoding
//   OVERRUN_CNT_W    width of the overrun event counter
//   OVERRUN_CNT_MAX  saturation value of the overrun event counter
//   GUARD_CNT_W      width of the guard-window down counter (covers GUARD_CYCLES up to 255)
package data_sync_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        GUARD   = 2'd2
    } state_e;

    localparam int OVERRUN_CNT_W   = 8;
    localparam int OVERRUN_CNT_MAX = 255;
    localparam int GUARD_CNT_W     = 8;

    // Increment that sticks at OVERRUN_CNT_MAX instead of wrapping.
    function automatic logic [OVERRUN_CNT_W-1:0] sat_inc(input logic [OVERRUN_CNT_W-1:0] v);
        return (v == OVERRUN_CNT_W'(OVERRUN_CNT_MAX)) ? v : v + OVERRUN_CNT_W'(1);
    endfunction

endpackage

// File: rtl/data_sync_sync_chain.sv
// sync_chain: NUM_STAGES-deep single-bit flop shifter for bringing a level
// signal into the clk_i domain. Also usable on acknowledge return paths.
//   clk_i  destination clock
//   rst_i  synchronous active-high reset, clears every stage
//   d_i    asynchronous level input
//   q_o    synchronized level (last stage)
module sync_chain #(
    parameter int NUM_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [NUM_STAGES-1:0] chain_q;
    logic [NUM_STAGES-1:0] chain_d;

    // Stage 0 takes the raw input; each later stage takes its predecessor.
    assign chain_d = {chain_q[NUM_STAGES-2:0], d_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) chain_q <= '0;
        else       chain_q <= chain_d;
    end

    assign q_o = chain_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync.sv
// data_sync: multi-bit bus synchronizer for the CLK domain. A level enable
// from the source domain is synchronized; its rising edge captures the
// quasi-static source bus and emits a one-cycle enable_pulse. A guard-window
// FSM flags enable edges that arrive too soon after the previous capture.
//   CLK           destination clock
//   RST           synchronous active-high reset
//   unsync_bus    source-domain data, stable while bus_enable is high
//   bus_enable    source-domain level enable (asynchronous)
//   sync_bus      captured data, held between captures
//   enable_pulse  one-cycle strobe marking a new sync_bus value
//   overrun       sticky: an enable edge landed inside the guard window
//   overrun_cnt   saturating count of overrun events
//   ack_toggle    (only with DATA_SYNC_ACK_EN) inverts on every capture
// Build option: define DATA_SYNC_ACK_EN to add the ack_toggle handshake output.
module data_sync
    import data_sync_pkg::*;
#(
    parameter int NUM_STAGES   = 2,
    parameter int BUS_WIDTH    = 8,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [BUS_WIDTH-1:0]     unsync_bus,
    input  logic                     bus_enable,
    output logic [BUS_WIDTH-1:0]     sync_bus,
    output logic                     enable_pulse,
    output logic                     overrun,
    output logic [OVERRUN_CNT_W-1:0] overrun_cnt
`ifdef DATA_SYNC_ACK_EN
    ,
    output logic                     ack_toggle
`endif
);

    logic                     en_sync;
    logic                     pulse_q;
    logic                     edge_det;
    logic [BUS_WIDTH-1:0]     sync_bus_q;
    logic                     enable_pulse_q;
    logic                     overrun_q;
    logic [OVERRUN_CNT_W-1:0] overrun_cnt_q;
    logic [GUARD_CNT_W-1:0]   guard_cnt_q, guard_cnt_d;
    state_e                   state_q, state_d;
    logic                     load_guard, dec_guard, set_ovr;

    sync_chain #(.NUM_STAGES(NUM_STAGES)) u_en_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (bus_enable),
        .q_o   (en_sync)
    );

    // Rising edge of the synchronized enable; a long-held enable fires once.
    assign edge_det = en_sync & ~pulse_q;

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (edge_det) state_d = CAPTURE;
            CAPTURE: state_d = GUARD;
            GUARD: begin
                if (edge_det)                state_d = CAPTURE;
                else if (guard_cnt_q == '0)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: guard counter control and overrun flagging
    always_comb begin
        load_guard = 1'b0;
        dec_guard  = 1'b0;
        set_ovr    = 1'b0;
        unique case (state_q)
            CAPTURE: load_guard = 1'b1;
            GUARD: begin
                if (edge_det) begin
                    set_ovr    = 1'b1;
                    load_guard = 1'b1;
                end else if (guard_cnt_q != '0) begin
                    dec_guard = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        guard_cnt_d = guard_cnt_q;
        if (load_guard)     guard_cnt_d = GUARD_CNT_W'(GUARD_CYCLES - 1);
        else if (dec_guard) guard_cnt_d = guard_cnt_q - GUARD_CNT_W'(1);
    end

    // Capture path and status registers. Capture happens on every edge, even
    // an overrun one; the flag only reports that the transfer was unsafe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pulse_q        <= 1'b0;
            sync_bus_q     <= '0;
            enable_pulse_q <= 1'b0;
            overrun_q      <= 1'b0;
            overrun_cnt_q  <= '0;
            guard_cnt_q    <= '0;
        end else begin
            pulse_q        <= en_sync;
            enable_pulse_q <= edge_det;
            guard_cnt_q    <= guard_cnt_d;
            if (edge_det) sync_bus_q <= unsync_bus;
            if (set_ovr) begin
                overrun_q     <= 1'b1;
                overrun_cnt_q <= sat_inc(overrun_cnt_q);
            end
        end
    end

    assign sync_bus     = sync_bus_q;
    assign enable_pulse = enable_pulse_q;
    assign overrun      = overrun_q;
    assign overrun_cnt  = overrun_cnt_q;

`ifdef DATA_SYNC_ACK_EN
    logic ack_q;

    always_ff @(posedge CLK) begin
        if (RST)           ack_q <= 1'b0;
        else if (edge_det) ack_q <= ~ack_q;
    end

    assign ack_toggle = ack_q;
`endif

endmodule

// File: tb/tb_data_sync.sv
module tb_data_sync;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] unsync_bus = 8'h00;
    logic       bus_enable = 1'b0;
    logic [7:0] sync_bus;
    logic       enable_pulse;
    logic       overrun;
    logic [7:0] overrun_cnt;
`ifdef DATA_SYNC_ACK_EN
    logic       ack_toggle;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8), .GUARD_CYCLES(4)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .unsync_bus   (unsync_bus),
        .bus_enable   (bus_enable),
        .sync_bus     (sync_bus),
        .enable_pulse (enable_pulse),
        .overrun      (overrun),
        .overrun_cnt  (overrun_cnt)
`ifdef DATA_SYNC_ACK_EN
        ,
        .ack_toggle   (ack_toggle)
`endif
    );

    // One row = inputs present at a posedge, outputs expected just after it.
    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] bus;
        logic [7:0] e_bus;
        logic       e_pulse;
        logic       e_ovr;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vec[$];

    function automatic void add(input int n, input logic rst, input logic en, input logic [7:0] bus,
                                input logic [7:0] e_bus, input logic e_pulse, input logic e_ovr,
                                input logic [7:0] e_cnt);
        for (int i = 0; i < n; i++) vec.push_back('{rst, en, bus, e_bus, e_pulse, e_ovr, e_cnt});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int   pulses;
        logic e_ack;

        // Reset held with enable and data already present; capture after release.
        add(3, 1, 1, 8'hA5, 8'h00, 0, 0, 0);
        add(2, 0, 1, 8'hA5, 8'h00, 0, 0, 0);
        add(1, 0, 1, 8'hA5, 8'hA5, 1, 0, 0);
        add(9, 0, 0, 8'hA5, 8'hA5, 0, 0, 0);
        // Enable held for 10 cycles: one pulse; later bus change is ignored.
        add(2, 0, 1, 8'h3C, 8'hA5, 0, 0, 0);
        add(1, 0, 1, 8'h3C, 8'h3C, 1, 0, 0);
        add(7, 0, 1, 8'h3C, 8'h3C, 0, 0, 0);
        add(10, 0, 0, 8'hFF, 8'h3C, 0, 0, 0);
        // Two enables 8 cycles apart: both captured, no overrun.
        add(2, 0, 1, 8'h11, 8'h3C, 0, 0, 0);
        add(1, 0, 0, 8'h11, 8'h11, 1, 0, 0);
        add(5, 0, 0, 8'h11, 8'h11, 0, 0, 0);
        add(2, 0, 1, 8'h22, 8'h11, 0, 0, 0);
        add(1, 0, 0, 8'h22, 8'h22, 1, 0, 0);
        add(8, 0, 0, 8'h22, 8'h22, 0, 0, 0);
        // Two enables 3 cycles apart: second lands in the guard window.
        add(1, 0, 1, 8'h55, 8'h22, 0, 0, 0);
        add(1, 0, 0, 8'h55, 8'h22, 0, 0, 0);
        add(1, 0, 0, 8'h55, 8'h55, 1, 0, 0);
        add(2, 0, 1, 8'h66, 8'h55, 0, 0, 0);
        vec[vec.size()-1].en = 1'b0;
        add(1, 0, 0, 8'h66, 8'h66, 1, 1, 1);
        add(8, 0, 0, 8'h66, 8'h66, 0, 1, 1);
        // Reset one cycle after enable rises, released while still high.
        add(1, 0, 1, 8'h77, 8'h66, 0, 1, 1);
        add(2, 1, 1, 8'h77, 8'h00, 0, 0, 0);
        add(2, 0, 1, 8'h77, 8'h00, 0, 0, 0);
        add(1, 0, 1, 8'h77, 8'h77, 1, 0, 0);
        add(9, 0, 0, 8'h77, 8'h77, 0, 0, 0);

        e_ack = 1'b0;
        for (int i = 0; i < vec.size(); i++) begin
            RST        = vec[i].rst;
            bus_enable = vec[i].en;
            unsync_bus = vec[i].bus;
            tick();
            chk($sformatf("row%0d sync_bus", i), 32'(sync_bus), 32'(vec[i].e_bus));
            chk($sformatf("row%0d enable_pulse", i), 32'(enable_pulse), 32'(vec[i].e_pulse));
            chk($sformatf("row%0d overrun", i), 32'(overrun), 32'(vec[i].e_ovr));
            chk($sformatf("row%0d overrun_cnt", i), 32'(overrun_cnt), 32'(vec[i].e_cnt));
            if (vec[i].rst)          e_ack = 1'b0;
            else if (vec[i].e_pulse) e_ack = ~e_ack;
`ifdef DATA_SYNC_ACK_EN
            chk($sformatf("row%0d ack_toggle", i), 32'(ack_toggle), 32'(e_ack));
`endif
        end

        // 301 enable edges two cycles apart: the first is clean, the other
        // 300 overrun; the counter must stop at 255 rather than wrap.
        pulses     = 0;
        unsync_bus = 8'hC3;
        for (int i = 0; i < 301; i++) begin
            for (int ph = 0; ph < 2; ph++) begin
                bus_enable = (ph == 0);
                tick();
                if (enable_pulse) begin
                    pulses++;
                    chk($sformatf("burst pulse%0d overrun_cnt", pulses), 32'(overrun_cnt),
                        32'((pulses - 1 > 255) ? 255 : pulses - 1));
                end
            end
        end
        bus_enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (enable_pulse) pulses++;
        end
        chk("burst pulse count", 32'(pulses), 32'd301);
        chk("burst overrun_cnt saturated", 32'(overrun_cnt), 32'd255);
        chk("burst overrun sticky", 32'(overrun), 32'd1);
        chk("burst sync_bus", 32'(sync_bus), 32'hC3);

        // Sticky flags survive idle time and clear only on reset.
        for (int i = 0; i < 10; i++) tick();
        chk("idle overrun_cnt held", 32'(overrun_cnt), 32'd255);
        RST = 1'b1;
        tick();
        chk("reset overrun", 32'(overrun), 32'd0);
        chk("reset overrun_cnt", 32'(overrun_cnt), 32'd0);
        chk("reset sync_bus", 32'(sync_bus), 32'd0);
`ifdef DATA_SYNC_ACK_EN
        chk("reset ack_toggle", 32'(ack_toggle), 32'd0);
`endif
        RST = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
